// File: rtl/sub32_byte_serial.sv
// Byte-serial subtractor: Diff = A - B - Bin, one SLICE-bit slice per clock, LSB first.
// Optional SUB32_BYTE_SERIAL_SKID_EN lets DONE hand off and accept new operands on the same edge.
module sub32_byte_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic              out_valid_q, out_valid_d, busy_q, busy_d;
  logic [SLICE-1:0]  a_sl, b_sl;
  logic [SLICE:0]    sum;
  logic              take;

  // Next-state, slice datapath and output decode
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    a_sl        = '0;
    b_sl        = '0;
    sum         = '0;
    take        = 1'b0;

    case (state_q)
      IDLE: take = in_valid;
      CALC: begin
        for (int k = 0; k < int'(NSLICE); k++) begin
          if (cnt_q == CW'(k)) begin
            a_sl = a_q[k*SLICE +: SLICE];
            b_sl = b_q[k*SLICE +: SLICE];
          end
        end
        // Subtract as A + ~B + carry-in, where carry-in is the inverted borrow
        sum = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, ~borrow_q};
        for (int k = 0; k < int'(NSLICE); k++) begin
          if (cnt_q == CW'(k)) diff_d[k*SLICE +: SLICE] = sum[SLICE-1:0];
        end
        borrow_d = ~sum[SLICE];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NSLICE - 1)) begin
          cnt_d   = '0;
          bout_d  = ~sum[SLICE];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[SLICE-1] != a_q[WIDTH-1]);
          zero_d  = (diff_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef SUB32_BYTE_SERIAL_SKID_EN
          take = in_valid;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      a_d      = A;
      b_d      = B;
      borrow_d = Bin;
      cnt_d    = '0;
      state_d  = CALC;
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SUB32_BYTE_SERIAL_SKID_EN
  // Ready in DONE follows the consumer so a handoff edge can also accept
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
  logic in_ready_q, in_ready_d;

  always_comb in_ready_d = (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) in_ready_q <= 1'b1;
    else        in_ready_q <= in_ready_d;
  end

  assign in_ready = in_ready_q;
`endif

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule
